// File: rtl/mem_ctrl_pkg.sv
// Shared types and default widths for the burst memory controller.
package mem_ctrl_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
  localparam int LEN_W_DEF  = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_READ   = 2'd2,
    ST_RDRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/mem_ctrl_if.sv
// Host-side request / write-beat / read-beat bus of the memory controller.
interface mem_ctrl_if #(
  parameter int ADDR_W = mem_ctrl_pkg::ADDR_W_DEF,
  parameter int DATA_W = mem_ctrl_pkg::DATA_W_DEF,
  parameter int LEN_W  = mem_ctrl_pkg::LEN_W_DEF
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic              wdata_valid;
  logic              wdata_ready;
  logic [DATA_W-1:0] wdata;
  logic              rdata_valid;
  logic [DATA_W-1:0] rdata;
  logic              rdata_last;
  logic              busy;

  modport master (
    output req_valid, req_write, req_addr, req_len, wdata_valid, wdata,
    input  req_ready, wdata_ready, rdata_valid, rdata, rdata_last, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_len, wdata_valid, wdata,
    output req_ready, wdata_ready, rdata_valid, rdata, rdata_last, busy
  );

endinterface

// File: rtl/mem_ctrl.sv
// Burst controller: turns host read/write bursts of 1..4 beats into single-port
// memory core accesses; read data returns one cycle after issue.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  mem_ctrl_if.slave         host,
  output logic              ce_mem,
  output logic              we_mem,
  output logic [ADDR_W-1:0] addr_mem,
  output logic [DATA_W-1:0] datai_mem,
  input  logic [DATA_W-1:0] datao_mem
);

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_beat;
  logic              r_rd_pending;
  logic              r_rd_last;
  logic              w_accept;
  logic              w_beat_fire;
  logic              w_last_beat;

  assign w_last_beat = (r_beat == '0);

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_beat_fire  = 1'b0;
    ce_mem       = 1'b0;
    we_mem       = 1'b0;
    addr_mem     = '0;
    datai_mem    = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (host.req_valid) begin
          w_accept     = 1'b1;
          w_state_next = host.req_write ? ST_WRITE : ST_READ;
        end
      end
      ST_WRITE: begin
        // A missing write beat stalls everything, including the address.
        if (host.wdata_valid) begin
          w_beat_fire = 1'b1;
          ce_mem      = 1'b1;
          we_mem      = 1'b1;
          addr_mem    = r_addr;
          datai_mem   = host.wdata;
          if (w_last_beat) begin
            w_state_next = ST_IDLE;
          end
        end
      end
      ST_READ: begin
        w_beat_fire = 1'b1;
        ce_mem      = 1'b1;
        addr_mem    = r_addr;
        if (w_last_beat) begin
          w_state_next = ST_RDRAIN;
        end
      end
      ST_RDRAIN: begin
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_beat       <= '0;
      r_rd_pending <= 1'b0;
      r_rd_last    <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_rd_pending <= (r_state == ST_READ);
      r_rd_last    <= (r_state == ST_READ) && w_last_beat;
      if (w_accept) begin
        r_addr <= host.req_addr;
        r_beat <= host.req_len;
      end else if (w_beat_fire) begin
        r_addr <= r_addr + 1'b1;
        r_beat <= r_beat - 1'b1;
      end
    end
  end

  assign host.req_ready   = (r_state == ST_IDLE);
  assign host.wdata_ready = (r_state == ST_WRITE);
  assign host.busy        = (r_state != ST_IDLE);
  assign host.rdata_valid = r_rd_pending;
  assign host.rdata_last  = r_rd_last;
  assign host.rdata       = datao_mem;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed plus randomized bursts against a memory-core model and a flat
// reference memory array.
module tb_mem_ctrl;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int LW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          ce_mem;
  logic          we_mem;
  logic [AW-1:0] addr_mem;
  logic [DW-1:0] datai_mem;
  logic [DW-1:0] datao_mem;

  mem_ctrl_if #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) bus ();

  mem_ctrl #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk       (clk),
    .reset     (reset),
    .host      (bus),
    .ce_mem    (ce_mem),
    .we_mem    (we_mem),
    .addr_mem  (addr_mem),
    .datai_mem (datai_mem),
    .datao_mem (datao_mem)
  );

  always #5 clk = ~clk;

  // Memory core: write on ce&we, registered read data on ce&~we.
  logic [DW-1:0] core_mem [256];
  always @(posedge clk) begin
    if (ce_mem) begin
      if (we_mem) core_mem[addr_mem] <= datai_mem;
      else        datao_mem <= core_mem[addr_mem];
    end
  end

  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] wbuf [4];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge in IDLE; returns just after the negedge of the
  // first IDLE cycle following the burst.
  task automatic do_write(input int addr, input int len, input int stall_beat,
                          input int stall_n, input bit rnd_stall);
    bus.req_valid   = 1'b1;
    bus.req_write   = 1'b1;
    bus.req_addr    = addr[AW-1:0];
    bus.req_len     = len[LW-1:0];
    bus.wdata_valid = 1'b1;
    bus.wdata       = 8'h5A;
    #1;
    chk("wr_accept_ready", bus.req_ready, 1);
    chk("wr_idle_ce_ignored", ce_mem, 0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      int ns;
      ns = (b == stall_beat) ? stall_n : (rnd_stall ? int'($urandom_range(0, 2)) : 0);
      for (int s = 0; s < ns; s++) begin
        bus.wdata_valid = 1'b0;
        bus.wdata       = 8'($urandom);
        #1;
        chk("wr_stall_ce", {ce_mem, we_mem}, 0);
        chk("wr_stall_addr", addr_mem, 0);
        chk("wr_stall_wready", bus.wdata_ready, 1);
        @(negedge clk);
      end
      bus.wdata_valid = 1'b1;
      bus.wdata       = wbuf[b];
      #1;
      chk("wr_ce_we", {ce_mem, we_mem}, 2'b11);
      chk("wr_addr", addr_mem, (addr + b) % 256);
      chk("wr_datai", datai_mem, wbuf[b]);
      chk("wr_busy_ready", {bus.busy, bus.req_ready}, 2'b10);
      ref_mem[(addr + b) % 256] = wbuf[b];
      @(negedge clk);
    end
    bus.wdata_valid = 1'b0;
    #1;
    chk("wr_done_ready", bus.req_ready, 1);
    chk("wr_done_busy_wready", {bus.busy, bus.wdata_ready}, 0);
  endtask

  // hold keeps req_valid high through the burst, presenting (naddr, nlen).
  task automatic do_read(input int addr, input int len, input bit hold,
                         input int naddr, input int nlen);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = addr[AW-1:0];
    bus.req_len   = len[LW-1:0];
    #1;
    chk("rd_accept_ready", bus.req_ready, 1);
    @(negedge clk);
    if (hold) begin
      bus.req_addr = naddr[AW-1:0];
      bus.req_len  = nlen[LW-1:0];
    end else begin
      bus.req_valid = 1'b0;
    end
    for (int i = 0; i <= len; i++) begin
      #1;
      chk("rd_ce_we", {ce_mem, we_mem}, 2'b10);
      chk("rd_addr", addr_mem, (addr + i) % 256);
      chk("rd_busy_ready", {bus.busy, bus.req_ready}, 2'b10);
      if (i > 0) begin
        chk("rd_valid_last", {bus.rdata_valid, bus.rdata_last}, 2'b10);
        chk("rd_data", bus.rdata, ref_mem[(addr + i - 1) % 256]);
      end else begin
        chk("rd_first_valid", bus.rdata_valid, 0);
      end
      @(negedge clk);
    end
    #1;
    chk("rd_drain_valid_last", {bus.rdata_valid, bus.rdata_last}, 2'b11);
    chk("rd_drain_data", bus.rdata, ref_mem[(addr + len) % 256]);
    chk("rd_drain_ce_addr", {ce_mem, addr_mem}, 0);
    chk("rd_drain_ready", bus.req_ready, 0);
    @(negedge clk);
    #1;
    chk("rd_idle_ready_busy", {bus.req_ready, bus.busy}, 2'b10);
    chk("rd_idle_valid_last", {bus.rdata_valid, bus.rdata_last}, 0);
  endtask

  initial begin
    reset           = 1'b1;
    bus.req_valid   = 1'b1;
    bus.req_write   = 1'b1;
    bus.req_addr    = 8'h33;
    bus.req_len     = 2'd3;
    bus.wdata_valid = 1'b1;
    bus.wdata       = 8'hC3;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_ready_busy", {bus.req_ready, bus.busy}, 2'b10);
    chk("rst_wready", bus.wdata_ready, 0);
    chk("rst_rvalid_last", {bus.rdata_valid, bus.rdata_last}, 0);
    chk("rst_ce_we", {ce_mem, we_mem}, 0);
    chk("rst_addr_data", {addr_mem, datai_mem}, 0);
    reset           = 1'b0;
    bus.req_valid   = 1'b0;
    bus.wdata_valid = 1'b0;
    @(negedge clk);

    // Preload every location so reads never see uninitialised core contents.
    for (int k = 0; k < 64; k++) begin
      for (int b = 0; b < 4; b++) wbuf[b] = 8'($urandom);
      do_write(k * 4, 3, -1, 0, 1'b0);
    end

    wbuf[0] = 8'hA0; wbuf[1] = 8'hA1; wbuf[2] = 8'hA2; wbuf[3] = 8'hA3;
    do_write(8'h10, 3, -1, 0, 1'b0);
    do_read(8'h10, 3, 1'b0, 0, 0);

    wbuf[0] = 8'hB0; wbuf[1] = 8'hB1; wbuf[2] = 8'hB2; wbuf[3] = 8'hB3;
    do_write(8'h10, 3, 1, 2, 1'b0);
    do_read(8'h10, 3, 1'b0, 0, 0);

    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; wbuf[3] = 8'h44;
    do_write(8'hFE, 3, -1, 0, 1'b0);
    do_read(8'hFE, 3, 1'b0, 0, 0);

    do_read(8'h7C, 0, 1'b0, 0, 0);

    do_read(8'h10, 3, 1'b1, 8'hFE, 3);
    do_read(8'hFE, 3, 1'b0, 0, 0);

    // Reset during the second beat of a 4-beat read.
    wbuf[0] = 8'h91; wbuf[1] = 8'h92; wbuf[2] = 8'h93; wbuf[3] = 8'h94;
    do_write(8'h40, 3, -1, 0, 1'b0);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 8'h40;
    bus.req_len   = 2'd3;
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
    chk("rst_mid_first_issue", {ce_mem, addr_mem}, {1'b1, 8'h40});
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_mid_ce", ce_mem, 0);
    chk("rst_mid_rvalid", bus.rdata_valid, 0);
    chk("rst_mid_ready_busy", {bus.req_ready, bus.busy}, 2'b10);
    do_read(8'h40, 3, 1'b0, 0, 0);

    for (int t = 0; t < 60; t++) begin
      int a;
      int l;
      a = int'($urandom_range(0, 255));
      l = int'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        for (int b = 0; b < 4; b++) wbuf[b] = 8'($urandom);
        do_write(a, l, -1, 0, 1'b1);
      end else begin
        do_read(a, l, 1'b0, 0, 0);
      end
    end

    @(negedge clk);
    for (int m = 0; m < 256; m++) begin
      chk($sformatf("mem_%0h", m), core_mem[m], ref_mem[m]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, memory address width (256 locations).
REQ-002 SHALL have parameter DATA_W, default 8, memory data width.
REQ-003 SHALL have parameter LEN_W, default 2, burst-length field width (1..4 beats).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  1  host request valid.
REQ-007 req_ready  output  1  controller can accept a request.
REQ-008 req_write  input  1  1=write burst, 0=read burst.
REQ-009 req_addr  input  ADDR_W  burst start address.
REQ-010 req_len  input  LEN_W  beats minus one.
REQ-011 wdata_valid  input  1  host write beat valid.
REQ-012 wdata_ready  output  1  controller consumes write beat.
REQ-013 wdata  input  DATA_W  write beat data.
REQ-014 rdata_valid  output  1  read beat valid; no backpressure.
REQ-015 rdata  output  DATA_W  read beat data.
REQ-016 rdata_last  output  1  final read beat of burst.
REQ-017 busy  output  1  burst in progress (state != IDLE).
REQ-018 ce_mem, we_mem  output  1 each  memory chip enable / write enable to core.
REQ-019 addr_mem  output  ADDR_W  memory address.
REQ-020 datai_mem  output  DATA_W  memory write data.
REQ-021 datao_mem  input  DATA_W  core read data, registered by core one cycle after ce_mem&~we_mem.

Function
REQ-022 States SHALL be IDLE, WRITE, READ, RDRAIN.
REQ-023 req_ready SHALL equal (state==IDLE); request accepted when req_valid&req_ready.
REQ-024 On accept: latch addr counter=req_addr, beat counter=req_len; go to WRITE if req_write else READ.
REQ-025 WRITE: wdata_ready=1; ce_mem=we_mem=wdata_valid; addr_mem=addr counter; datai_mem=wdata (combinational passthrough).
REQ-026 WRITE stall: wdata_valid=0 SHALL hold ce_mem=0 and all counters.
REQ-027 Each accepted beat SHALL increment addr counter mod 2^ADDR_W (255->0 wrap) and decrement beat counter.
REQ-028 Write beat with beat counter==0 SHALL return to IDLE next cycle.
REQ-029 READ: ce_mem=1, we_mem=0 every cycle; addr_mem=addr counter; one beat issued per cycle, no stalls.
REQ-030 Read beat with beat counter==0 SHALL go to RDRAIN; RDRAIN lasts one cycle, then IDLE.
REQ-031 Registered rd_pending flag SHALL be set in the cycle after each read issue; rdata_valid=rd_pending, rdata=datao_mem.
REQ-032 Read latency: beat issued cycle N -> rdata_valid cycle N+1; bursts yield len+1 consecutive valid cycles.
REQ-033 rdata_last SHALL assert with the rdata_valid of the final issued beat only.
REQ-034 Outside WRITE/READ, ce_mem=we_mem=0; addr_mem and datai_mem SHALL be 0 when ce_mem=0.
REQ-035 req_valid during non-IDLE SHALL be ignored (held off by req_ready=0); wdata_valid outside WRITE SHALL be ignored.
REQ-036 Back-to-back requests: next accept no earlier than the IDLE cycle after completion.

Reset
REQ-037 reset SHALL force state=IDLE, counters=0, rd_pending=0 at the next edge, overriding all inputs.
REQ-038 After reset: req_ready=1, busy=0, wdata_ready=0, rdata_valid=0, rdata_last=0, ce_mem=we_mem=0, addr_mem=datai_mem=0.
REQ-039 Reset mid-burst SHALL abort: no further ce_mem, and no rdata_valid for a beat issued in the reset cycle.

Structure
REQ-040 Package mem_ctrl_pkg SHALL hold the state enum and ADDR_W/DATA_W/LEN_W defaults.
REQ-041 Single module; no sub-module is natural; the FSM, addr counter, beat counter and rd_pending live in mem_ctrl.
REQ-042 Memory-side port names SHALL match the core's interface signals so they connect one-to-one.

Verification (bench includes the memory core model)
REQ-043 Write addr 0x10 len 3, data A0..A3 one per cycle -> ce_mem&we_mem 4 cycles, addrs 0x10..0x13; read back returns A0..A3, rdata_last on 4th.
REQ-044 Write len 3 with wdata_valid low 2 cycles after beat 1 -> ce_mem low 2 cycles, addr holds 0x11, 4 beats total written.
REQ-045 Read addr 0xFE len 3 after writing 11,22,33,44 there -> addr_mem FE,FF,00,01; rdata 11,22,33,44 at issue+1.
REQ-046 Single-beat read (len 0) -> rdata_valid and rdata_last same cycle, req_ready high 2 cycles after accept.
REQ-047 req_valid held high during read burst -> second request accepted only after IDLE; first burst unaffected.
REQ-048 reset asserted on 2nd beat of len-3 read -> next cycle ce_mem=0, rdata_valid=0, req_ready=1; location contents unchanged.
